// File: rtl/riscv_imem_arb.sv
// riscv_imem_arb: single-port instruction memory arbiter for fetch and loader requesters
module riscv_imem_arb #(
  parameter int DLY_MEM    = 1,
  parameter int INST_WIDTH = 32,
  parameter int PC_WIDTH   = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [PC_WIDTH-1:0]   f_addr,
  input  logic                  f_flush,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [INST_WIDTH-1:0] f_rdata,
  output logic                  f_err,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [PC_WIDTH-1:0]   l_addr,
  input  logic [INST_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [INST_WIDTH-1:0] l_rdata,
  output logic                  l_err,
  output logic                  m_en,
  output logic                  m_we,
  output logic [PC_WIDTH-3:0]   m_addr,
  output logic [INST_WIDTH-1:0] m_wdata,
  input  logic [INST_WIDTH-1:0] m_rdata
);
  localparam int CW = DLY_MEM > 1 ? $clog2(DLY_MEM) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  keep_q, keep_d;
  logic [2:0]            starve_q, starve_d;
  logic                  f_rvalid_d, f_err_d, l_rvalid_d, l_err_d;
  logic [INST_WIDTH-1:0] f_rdata_d, l_rdata_d;
  logic                  idle, pick_l, mis, cap, f_fire, l_fire;
  logic [PC_WIDTH-1:0]   g_addr;
  // grant selection, memory strobe, next state and response generation
  always_comb begin
    idle       = state_q == IDLE && !reset;
    pick_l     = l_req && (!f_req || starve_q == 3'(STARVE_MAX));
    f_gnt      = idle && f_req && !pick_l;
    l_gnt      = idle && pick_l;
    g_addr     = l_gnt ? l_addr : f_addr;
    mis        = |g_addr[1:0];
    m_en       = (f_gnt || l_gnt) && !mis;
    m_we       = m_en && l_gnt && l_we;
    m_addr     = m_en ? g_addr[PC_WIDTH-1:2] : '0;
    m_wdata    = m_we ? l_wdata : '0;
    cap        = state_q == BUSY && cnt_q == '0;
    state_d    = m_en ? BUSY : cap ? IDLE : state_q;
    cnt_d      = m_en ? CW'(DLY_MEM - 1) : (state_q == BUSY && !cap) ? cnt_q - 1'b1 : cnt_q;
    owner_d    = m_en ? l_gnt : owner_q;
    we_d       = m_en ? m_we : we_q;
    keep_d     = (m_en && f_gnt) ? 1'b1 : (f_flush && state_q == BUSY && !owner_q) ? 1'b0 : keep_q;
    starve_d   = l_gnt ? 3'd0 : !f_gnt ? starve_q : !l_req ? 3'd0 :
                 starve_q == 3'(STARVE_MAX) ? starve_q : starve_q + 3'd1;
    f_fire     = (f_gnt && mis) || (cap && !owner_q && keep_q && !f_flush);
    l_fire     = (l_gnt && mis) || (cap && owner_q);
    f_rvalid_d = f_fire;
    f_err_d    = f_gnt && mis;
    f_rdata_d  = (f_gnt && mis) ? '0 : f_fire ? m_rdata : f_rdata;
    l_rvalid_d = l_fire;
    l_err_d    = l_gnt && mis;
    l_rdata_d  = (l_gnt && mis) ? '0 : l_fire ? (we_q ? '0 : m_rdata) : l_rdata;
  end
  // state and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      keep_q   <= 1'b0;
      starve_q <= '0;
      f_rvalid <= 1'b0;
      f_err    <= 1'b0;
      f_rdata  <= '0;
      l_rvalid <= 1'b0;
      l_err    <= 1'b0;
      l_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      keep_q   <= keep_d;
      starve_q <= starve_d;
      f_rvalid <= f_rvalid_d;
      f_err    <= f_err_d;
      f_rdata  <= f_rdata_d;
      l_rvalid <= l_rvalid_d;
      l_err    <= l_err_d;
      l_rdata  <= l_rdata_d;
    end
  end
endmodule

// File: tb/tb_riscv_imem_arb.sv
// tb_riscv_imem_arb: scoreboard bench for the instruction memory arbiter
module tb_riscv_imem_arb;
  localparam int DLY = 2;
  typedef struct {int cyc; logic err; logic [31:0] data;} exp_t;
  logic clk = 0, reset = 1;
  logic f_req = 0, f_flush = 0, l_req = 0, l_we = 0;
  logic [14:0] f_addr = 0, l_addr = 0;
  logic [31:0] l_wdata = 0;
  logic f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, m_en, m_we;
  logic [31:0] f_rdata, l_rdata, m_wdata, m_rdata;
  logic [12:0] m_addr;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] pipe [DLY];
  exp_t fq[$], lq[$];
  int checks = 0, failures = 0, cyc = 0;
  bit exp_l [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  riscv_imem_arb #(.DLY_MEM(DLY), .INST_WIDTH(32), .PC_WIDTH(15), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err), .l_req(l_req), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err), .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[5:0]] <= m_wdata;
    pipe[0] <= mem[m_addr[5:0]];
    for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
  end
  assign m_rdata = pipe[DLY-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (f_rvalid) begin
      if (fq.size() == 0) chk("f_unexp", f_rvalid, 0);
      else begin
        e = fq.pop_front();
        chk("f_cyc", cyc, e.cyc);
        chk("f_err", f_err, e.err);
        chk("f_rdata", f_rdata, e.data);
      end
    end
    if (l_rvalid) begin
      if (lq.size() == 0) chk("l_unexp", l_rvalid, 0);
      else begin
        e = lq.pop_front();
        chk("l_cyc", cyc, e.cyc);
        chk("l_err", l_err, e.err);
        chk("l_rdata", l_rdata, e.data);
      end
    end
  end

  task automatic issue(input bit is_l, input bit we, input logic [14:0] a, input logic [31:0] wd,
                       input bit push, output int t);
    bit mis, got;
    exp_t e;
    mis = |a[1:0];
    got = 0;
    t = -1;
    if (is_l) begin l_req = 1; l_we = we; l_addr = a; l_wdata = wd; end
    else begin f_req = 1; f_addr = a; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (is_l ? l_gnt : f_gnt) begin got = 1; t = cyc; end
    end
    chk("gnt_seen", got, 1);
    if (got) begin
      chk("m_en", m_en, !mis);
      if (!mis) begin
        chk("m_addr", m_addr, a[14:2]);
        chk("m_we", m_we, is_l && we);
        if (is_l && we) chk("m_wdata", m_wdata, wd);
      end
      e.cyc = t + (mis ? 1 : DLY + 1);
      e.err = mis;
      e.data = (mis || (is_l && we)) ? 32'h0 : ref_mem[a[7:2]];
      if (is_l && we && !mis) ref_mem[a[7:2]] = wd;
      if (push) begin if (is_l) lq.push_back(e); else fq.push_back(e); end
    end
    @(posedge clk); #1;
    f_req = 0;
    l_req = 0;
  endtask

  initial begin
    int t, t0, n, last, r0;
    bit got;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[1] = 32'h0050_0093;
    ref_mem[1] = 32'h0050_0093;
    f_req = 1; f_addr = 15'h4; l_req = 1; l_addr = 15'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    @(posedge clk); #1;
    reset = 0; f_req = 0; l_req = 0;
    repeat (2) @(posedge clk); #1;

    issue(0, 0, 15'h0004, 0, 1, t);
    issue(1, 1, 15'h0010, 32'hDEAD_BEEF, 1, t);
    issue(0, 0, 15'h0006, 0, 1, t);
    issue(1, 0, 15'h0013, 0, 1, t);
    issue(1, 0, 15'h0010, 0, 1, t);
    issue(0, 0, 15'h0010, 0, 1, t);

    f_req = 1; f_addr = 15'h4; l_req = 1; l_we = 0; l_addr = 15'h8;
    n = 0; last = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (f_gnt || l_gnt) begin
        chk("arb_order", l_gnt, exp_l[n]);
        if (n > 0) chk("arb_gap", cyc - last, DLY + 1);
        last = cyc;
        e.cyc = cyc + DLY + 1; e.err = 0; e.data = l_gnt ? ref_mem[2] : ref_mem[1];
        if (l_gnt) lq.push_back(e); else fq.push_back(e);
        n++;
      end
    end
    chk("arb_count", n, 10);
    @(posedge clk); #1;
    f_req = 0; l_req = 0;

    f_req = 1; f_addr = 15'h8; got = 0; t0 = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (f_gnt) begin got = 1; t0 = cyc; end
    end
    chk("flush_gnt", got, 1);
    @(posedge clk); #1;
    f_req = 0; f_flush = 1;
    @(posedge clk); #1;
    f_flush = 0;
    issue(0, 0, 15'h000C, 0, 1, t);
    chk("flush_next_gnt", t, t0 + DLY + 1);

    f_req = 1; f_addr = 15'h20; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (f_gnt) got = 1;
    end
    chk("rst_busy_gnt", got, 1);
    @(posedge clk); #1;
    reset = 1; f_req = 0;
    @(posedge clk); #1;
    f_req = 1; f_addr = 15'h4;
    @(negedge clk);
    chk("rst2_f_rdata", f_rdata, 0);
    chk("rst2_l_rdata", l_rdata, 0);
    chk("rst2_f_gnt", f_gnt, 0);
    chk("rst2_m_en", m_en, 0);
    chk("rst2_f_rvalid", f_rvalid, 0);
    @(posedge clk); #1;
    reset = 0;
    r0 = cyc;
    issue(0, 0, 15'h0004, 0, 1, t);
    chk("rst_first_gnt", t, r0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("f_drain", fq.size(), 0);
    chk("l_drain", lq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
